// File: rtl/gbar_collector.sv
`default_nettype none
// ============================================================================
// gbar_collector
//   Cluster global barrier collector: round-robin accepts per-core arrivals,
//   tracks per-id arrival masks and broadcasts a one-cycle release pulse.
//   Revision: 1.0
// ============================================================================
module gbar_collector #(
  parameter int NUM_CORES = 4,
  parameter int NUM_BARS  = 8,
  parameter int NB_W      = $clog2(NUM_BARS),
  parameter int NC_W      = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_CORES-1:0]      req_valid,
  input  logic [NUM_CORES*NB_W-1:0] req_id,
  input  logic [NUM_CORES*NC_W-1:0] req_size_m1,
  output logic [NUM_CORES-1:0]      req_ready,
  output logic                      rsp_valid,
  output logic [NB_W-1:0]           rsp_id,
  output logic                      dup_err
);

  localparam logic [NC_W-1:0] PTR_RST = NC_W'(NUM_CORES - 1);
  localparam logic [NC_W:0]   NC_L    = (NC_W+1)'(NUM_CORES);

  logic [NC_W-1:0]      ptr_q, ptr_d;
  logic [NUM_CORES-1:0] mask_q [NUM_BARS];
  logic [NUM_CORES-1:0] mask_d [NUM_BARS];
  logic                 rsp_valid_q, rsp_valid_d;
  logic [NB_W-1:0]      rsp_id_q, rsp_id_d;
  logic                 dup_err_q, dup_err_d;

  logic [NC_W:0]        cand_sum;
  logic [NC_W-1:0]      cand;
  logic                 found;
  logic [NC_W-1:0]      gnt_idx;
  logic [NUM_CORES-1:0] grant;

  // Search starts one past the last winner so every port gets a turn.
  always_comb begin
    found    = 1'b0;
    gnt_idx  = ptr_q;
    cand_sum = '0;
    cand     = '0;
    for (int k = 1; k <= NUM_CORES; k++) begin
      cand_sum = {1'b0, ptr_q} + (NC_W+1)'(k);
      if (cand_sum >= NC_L) begin
        cand_sum = cand_sum - NC_L;
      end
      cand = cand_sum[NC_W-1:0];
      if (!found && req_valid[cand]) begin
        found   = 1'b1;
        gnt_idx = cand;
      end
    end
    grant = found ? (NUM_CORES'(1) << gnt_idx) : '0;
  end

  assign req_ready = grant;

  logic [NB_W-1:0]      sel_id;
  logic [NC_W-1:0]      sel_size;
  logic [NUM_CORES-1:0] old_mask;
  logic [NUM_CORES-1:0] new_mask;
  logic [NC_W:0]        arrived;
  logic [NC_W:0]        needed;
  logic                 done;

  always_comb begin
    sel_id   = req_id[int'(gnt_idx)*NB_W +: NB_W];
    sel_size = req_size_m1[int'(gnt_idx)*NC_W +: NC_W];
    old_mask = mask_q[sel_id];
    new_mask = old_mask | grant;
    arrived  = '0;
    for (int j = 0; j < NUM_CORES; j++) begin
      arrived = arrived + (NC_W+1)'(new_mask[j]);
    end
    needed = (NC_W+1)'(sel_size) + (NC_W+1)'(1);
    // Overshoot means the cores disagree on size; release rather than hang.
    done   = (arrived >= needed);
  end

  always_comb begin
    mask_d      = mask_q;
    ptr_d       = ptr_q;
    rsp_valid_d = 1'b0;
    rsp_id_d    = rsp_id_q;
    dup_err_d   = dup_err_q;
    if (found) begin
      ptr_d          = gnt_idx;
      mask_d[sel_id] = done ? '0 : new_mask;
      if (|(old_mask & grant)) begin
        dup_err_d = 1'b1;
      end
      if (done) begin
        rsp_valid_d = 1'b1;
        rsp_id_d    = sel_id;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q       <= PTR_RST;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      dup_err_q   <= 1'b0;
      for (int b = 0; b < NUM_BARS; b++) begin
        mask_q[b] <= '0;
      end
    end else begin
      ptr_q       <= ptr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      dup_err_q   <= dup_err_d;
      for (int b = 0; b < NUM_BARS; b++) begin
        mask_q[b] <= mask_d[b];
      end
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign dup_err   = dup_err_q;

endmodule
`default_nettype wire

// File: tb/tb_gbar_collector.sv
`default_nettype none
// ============================================================================
// tb_gbar_collector
//   Directed scenarios plus random traffic against a set-based barrier model.
//   Revision: 1.0
// ============================================================================
module tb_gbar_collector;

  localparam int NC   = 4;
  localparam int NB   = 8;
  localparam int NB_W = 3;
  localparam int NC_W = 2;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [NC-1:0]        req_valid;
  logic [NC*NB_W-1:0]   req_id;
  logic [NC*NC_W-1:0]   req_size_m1;
  logic [NC-1:0]        req_ready;
  logic                 rsp_valid;
  logic [NB_W-1:0]      rsp_id;
  logic                 dup_err;

  gbar_collector #(.NUM_CORES(NC), .NUM_BARS(NB)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_id      (req_id),
    .req_size_m1 (req_size_m1),
    .req_ready   (req_ready),
    .rsp_valid   (rsp_valid),
    .rsp_id      (rsp_id),
    .dup_err     (dup_err)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // Reference state: who has arrived at each barrier, and what was released.
  int            m_ptr;
  logic [NC-1:0] m_mask [NB];
  logic          m_rsp_v;
  logic [NB_W-1:0] m_rsp_id;
  logic          m_dup;
  int            r_id [NC];
  int            r_sz [NC];
  int            last_g;
  logic [NC-1:0] last_rdy;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int p, input int id, input int sz);
    r_id[p] = id;
    r_sz[p] = sz;
    req_valid[p] = 1'b1;
    req_id[p*NB_W +: NB_W] = NB_W'(id);
    req_size_m1[p*NC_W +: NC_W] = NC_W'(sz);
  endtask

  task automatic clr_req(input int p);
    req_valid[p] = 1'b0;
  endtask

  task automatic model_reset();
    m_ptr = NC - 1;
    for (int b = 0; b < NB; b++) m_mask[b] = '0;
    m_rsp_v  = 1'b0;
    m_rsp_id = '0;
    m_dup    = 1'b0;
  endtask

  function automatic int model_grant();
    for (int k = 1; k <= NC; k++) begin
      if (req_valid[(m_ptr + k) % NC]) return (m_ptr + k) % NC;
    end
    return -1;
  endfunction

  task automatic model_arrive(input int g);
    int b;
    int s;
    b = r_id[g];
    s = r_sz[g];
    if (m_mask[b][g]) m_dup = 1'b1;
    m_mask[b][g] = 1'b1;
    if ($countones(m_mask[b]) >= s + 1) begin
      m_mask[b] = '0;
      m_rsp_v   = 1'b1;
      m_rsp_id  = b[NB_W-1:0];
    end
    m_ptr = g;
  endtask

  // One clock: check the grant before the edge, the response after it.
  task automatic cycle();
    int g;
    logic [NC-1:0] exp_rdy;
    #1;
    g = model_grant();
    exp_rdy = (g >= 0) ? (NC'(1) << g) : '0;
    chk("req_ready", 32'(req_ready), 32'(exp_rdy));
    last_rdy = req_ready;
    last_g   = g;
    @(posedge clk);
    if (reset) begin
      model_reset();
    end else begin
      m_rsp_v = 1'b0;
      if (g >= 0) model_arrive(g);
    end
    #1;
    chk("rsp_valid", 32'(rsp_valid), 32'(m_rsp_v));
    chk("rsp_id", 32'(rsp_id), 32'(m_rsp_id));
    chk("dup_err", 32'(dup_err), 32'(m_dup));
    @(negedge clk);
  endtask

  initial begin
    logic [NC-1:0] onehot;
    reset       = 1'b1;
    req_valid   = '0;
    req_id      = '0;
    req_size_m1 = '0;
    for (int p = 0; p < NC; p++) begin
      r_id[p] = 0;
      r_sz[p] = 0;
    end
    last_g   = -1;
    last_rdy = '0;
    model_reset();

    @(posedge clk);
    #1;
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_id", 32'(rsp_id), 32'd0);
    chk("rst_dup_err", 32'(dup_err), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    cycle();
    reset = 1'b0;

    // Full arrival at id 3, one port per cycle.
    for (int p = 0; p < NC; p++) begin
      set_req(p, 3, 3);
      cycle();
      onehot = NC'(1) << p;
      chk("full_grant", 32'(last_rdy), 32'(onehot));
      chk("full_rsp", 32'(rsp_valid), (p == NC - 1) ? 32'd1 : 32'd0);
      clr_req(p);
    end
    chk("full_rsp_id", 32'(rsp_id), 32'd3);
    cycle();
    chk("full_pulse_end", 32'(rsp_valid), 32'd0);

    // Simultaneous arrival at id 5.
    for (int p = 0; p < NC; p++) set_req(p, 5, 3);
    for (int i = 0; i < NC; i++) begin
      cycle();
      onehot = NC'(1) << i;
      chk("simul_grant", 32'(last_rdy), 32'(onehot));
      if (last_g >= 0) clr_req(last_g);
    end
    chk("simul_rsp", 32'(rsp_valid), 32'd1);
    chk("simul_rsp_id", 32'(rsp_id), 32'd5);
    cycle();

    // Fairness between two persistent requesters.
    set_req(1, 2, 3);
    set_req(2, 4, 3);
    for (int i = 0; i < 6; i++) begin
      cycle();
      chk("rr_alt", 32'(last_rdy), (i % 2 == 0) ? 32'h2 : 32'h4);
    end
    clr_req(1);
    clr_req(2);
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    chk("rr_reset_dup", 32'(dup_err), 32'd0);

    // Partial subset, then reuse of the same id.
    set_req(2, 0, 1); cycle(); clr_req(2);
    set_req(0, 0, 1); cycle(); clr_req(0);
    chk("sub_rsp", 32'(rsp_valid), 32'd1);
    chk("sub_rsp_id", 32'(rsp_id), 32'd0);
    set_req(2, 0, 1); cycle(); clr_req(2);
    chk("reuse_no_rsp", 32'(rsp_valid), 32'd0);
    chk("reuse_no_dup", 32'(dup_err), 32'd0);
    set_req(1, 0, 1); cycle(); clr_req(1);
    chk("reuse_done", 32'(rsp_valid), 32'd1);

    // Duplicate arrival.
    set_req(1, 1, 2); cycle(); cycle(); clr_req(1);
    chk("dup_flag", 32'(dup_err), 32'd1);
    chk("dup_no_rsp", 32'(rsp_valid), 32'd0);
    set_req(3, 1, 2); cycle(); clr_req(3);
    chk("dup_partial", 32'(rsp_valid), 32'd0);
    set_req(0, 1, 2); cycle(); clr_req(0);
    chk("dup_done", 32'(rsp_valid), 32'd1);
    chk("dup_sticky", 32'(dup_err), 32'd1);

    // Reset mid-operation discards partial arrivals.
    for (int p = 0; p < 3; p++) begin
      set_req(p, 7, 3); cycle(); clr_req(p);
    end
    reset = 1'b1;
    cycle();
    chk("mid_rst_rsp", 32'(rsp_valid), 32'd0);
    reset = 1'b0;
    set_req(3, 7, 3); cycle(); clr_req(3);
    chk("mid_rst_no_rsp", 32'(rsp_valid), 32'd0);
    chk("mid_rst_dup", 32'(dup_err), 32'd0);

    // A completing arrival coincident with reset must not release.
    set_req(0, 6, 0);
    reset = 1'b1;
    cycle();
    chk("rst_suppress", 32'(rsp_valid), 32'd0);
    reset = 1'b0;
    cycle();
    chk("post_rst_done", 32'(rsp_valid), 32'd1);
    chk("post_rst_id", 32'(rsp_id), 32'd6);
    clr_req(0);

    // Random traffic, requests held until accepted.
    for (int i = 0; i < 400; i++) begin
      for (int p = 0; p < NC; p++) begin
        if (!req_valid[p] && $urandom_range(1, 0) == 1)
          set_req(p, int'($urandom_range(3, 0)), int'($urandom_range(3, 0)));
      end
      reset = ($urandom_range(39, 0) == 0);
      cycle();
      if (!reset && last_g >= 0) clr_req(last_g);
    end
    reset = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
